// File: rtl/hazard.sv
// -----------------------------------------------------------------------------
// hazard -- pipeline hazard unit for a five-stage in-order core.
//
// Tracks shadow copies of the E and M pipeline slots, uses them to resolve
// operand sources, and produces per-stage stall and flush controls.
//
// Ports
//   clk, rstn              clock; asynchronous active-low reset
//   is_b/is_j/is_load/is_m/is_d   D-stage instruction class
//   dst_en, r_dst          D-stage register write enable / destination
//   r_src1, r_src2         D-stage source registers
//   pre_taken, real_taken  D-stage branch prediction / E-stage branch outcome
//   fin                    mul/div result ready
//   f_cmiss, f_arrival     instruction cache miss / refill data returned
//   m_cmiss, m_arrival     data cache miss / refill data returned
//   src1_sel, src2_sel     00 regfile, 01 E bypass, 10 M bypass
//   fd_st..mw_st           hold IF/ID, ID/EX, EX/MEM, MEM/WB
//   rs1_depended_h_o       D-stage jump's rs1 is still in flight
//   flush_o                branch mispredict, kill D-stage instruction
//
// Configuration
//   HAZARD_FWD_EN defined  : E/M bypassing, stall only on load-use.
//   HAZARD_FWD_EN undefined: no bypassing, any in-flight producer stalls D.
// -----------------------------------------------------------------------------
module hazard (
    input  logic       clk,
    input  logic       rstn,
    input  logic       is_b,
    input  logic       is_j,
    input  logic       is_load,
    input  logic       is_m,
    input  logic       is_d,
    input  logic       dst_en,
    input  logic [4:0] r_dst,
    input  logic [4:0] r_src1,
    input  logic [4:0] r_src2,
    input  logic       pre_taken,
    input  logic       real_taken,
    input  logic       fin,
    input  logic       f_cmiss,
    input  logic       m_cmiss,
    input  logic       f_arrival,
    input  logic       m_arrival,
    output logic [1:0] src1_sel,
    output logic [1:0] src2_sel,
    output logic       fd_st,
    output logic       de_st,
    output logic       em_st,
    output logic       mw_st,
    output logic       rs1_depended_h_o,
    output logic       flush_o
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t  state_reg, state_next;

    logic       e_en_reg, e_load_reg, e_b_reg, e_pt_reg;
    logic [4:0] e_dst_reg;
    logic       m_en_reg;
    logic [4:0] m_dst_reg;

    logic [4:0] src_w [2];
    logic [1:0] sel_w [2];
    logic [1:0] e_hit;
    logic [1:0] m_hit;

    logic       dmiss_stall, fmiss_stall, md_stall, data_stall;
    logic       load_use;

    assign src_w[0] = r_src1;
    assign src_w[1] = r_src2;

    // Register 0 is hardwired, so it never depends on an in-flight write.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign e_hit[gi] = e_en_reg && (src_w[gi] != 5'd0) && (src_w[gi] == e_dst_reg);
            assign m_hit[gi] = m_en_reg && (src_w[gi] != 5'd0) && (src_w[gi] == m_dst_reg);
`ifdef HAZARD_FWD_EN
            // A load in E has no data yet, so during load-use read the
            // regfile and let the bubble bring the value to M next cycle.
            assign sel_w[gi] = load_use                     ? 2'b00 :
                               (e_hit[gi] && !e_load_reg)   ? 2'b01 :
                               m_hit[gi]                    ? 2'b10 : 2'b00;
`else
            assign sel_w[gi] = 2'b00;
`endif
        end
    endgenerate

    assign src1_sel = sel_w[0];
    assign src2_sel = sel_w[1];

    assign flush_o          = e_b_reg && (real_taken ^ e_pt_reg);
    assign rs1_depended_h_o = is_j && (e_hit[0] || m_hit[0]);

    // A killed D instruction has no operands to wait for.
    assign load_use = (|e_hit) && e_load_reg && !flush_o;
`ifdef HAZARD_FWD_EN
    assign data_stall = load_use;
`else
    // Without bypassing a non-load producer in E or any producer in M
    // blocks D just like a load does.
    assign data_stall = load_use ||
                        (((|e_hit) && !e_load_reg || (|m_hit)) && !flush_o);
`endif

    assign dmiss_stall = m_cmiss && !m_arrival;
    assign fmiss_stall = f_cmiss && !f_arrival;
    assign md_stall    = (state_reg == BUSY) && !fin;

    // Each stage's hold implies the hold of every earlier stage.
    assign mw_st = dmiss_stall;
    assign em_st = mw_st || md_stall;
    assign de_st = em_st || data_stall;
    assign fd_st = de_st || fmiss_stall;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if ((is_m || is_d) && !de_st) state_next = BUSY;
            BUSY: if (fin)                      state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            e_en_reg   <= 1'b0;
            e_dst_reg  <= 5'd0;
            e_load_reg <= 1'b0;
            e_b_reg    <= 1'b0;
            e_pt_reg   <= 1'b0;
            m_en_reg   <= 1'b0;
            m_dst_reg  <= 5'd0;
        end else begin
            state_reg <= state_next;

            if (flush_o || (de_st && !em_st)) begin
                e_en_reg   <= 1'b0;
                e_load_reg <= 1'b0;
                e_b_reg    <= 1'b0;
                e_pt_reg   <= 1'b0;
            end else if (!de_st) begin
                e_en_reg   <= dst_en;
                e_dst_reg  <= r_dst;
                e_load_reg <= is_load;
                e_b_reg    <= is_b;
                e_pt_reg   <= pre_taken;
            end

            if (!em_st) begin
                m_en_reg  <= e_en_reg;
                m_dst_reg <= e_dst_reg;
            end
        end
    end

endmodule

// File: tb/tb_hazard.sv
// -----------------------------------------------------------------------------
// tb_hazard -- directed self-checking bench for hazard.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well before the next rising edge. Observed outputs are packed as
// {src1_sel, src2_sel, fd_st, de_st, em_st, mw_st, rs1_depended_h_o, flush_o}.
// -----------------------------------------------------------------------------
module tb_hazard;

    logic       clk = 1'b0;
    logic       rstn;
    logic       is_b, is_j, is_load, is_m, is_d, dst_en;
    logic [4:0] r_dst, r_src1, r_src2;
    logic       pre_taken, real_taken, fin;
    logic       f_cmiss, m_cmiss, f_arrival, m_arrival;
    logic [1:0] src1_sel, src2_sel;
    logic       fd_st, de_st, em_st, mw_st, rs1_depended_h_o, flush_o;

    int checks = 0;
    int errors = 0;

    logic [9:0] outs;
    assign outs = {src1_sel, src2_sel, fd_st, de_st, em_st, mw_st, rs1_depended_h_o, flush_o};

    hazard dut (
        .clk(clk), .rstn(rstn),
        .is_b(is_b), .is_j(is_j), .is_load(is_load), .is_m(is_m), .is_d(is_d),
        .dst_en(dst_en), .r_dst(r_dst), .r_src1(r_src1), .r_src2(r_src2),
        .pre_taken(pre_taken), .real_taken(real_taken), .fin(fin),
        .f_cmiss(f_cmiss), .m_cmiss(m_cmiss), .f_arrival(f_arrival), .m_arrival(m_arrival),
        .src1_sel(src1_sel), .src2_sel(src2_sel),
        .fd_st(fd_st), .de_st(de_st), .em_st(em_st), .mw_st(mw_st),
        .rs1_depended_h_o(rs1_depended_h_o), .flush_o(flush_o)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs;
        is_b = 0; is_j = 0; is_load = 0; is_m = 0; is_d = 0; dst_en = 0;
        r_dst = 0; r_src1 = 0; r_src2 = 0; pre_taken = 0; real_taken = 0; fin = 0;
        f_cmiss = 0; m_cmiss = 0; f_arrival = 0; m_arrival = 0;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drain;
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_reset;
        logic [9:0] exp;
        clear_inputs();
        rstn = 0;
        #2;
        exp = 10'b00_00_0000_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL reset_outputs: got %b expected %b", outs, exp); errors++;
        end
        $display("reset: outs=%b", outs);
        tick();
        rstn = 1;
        tick();
    endtask

    task automatic test_forward;
        logic [9:0] exp;
        clear_inputs(); dst_en = 1; r_dst = 5;          // add x5 enters E
        tick();
        clear_inputs(); r_src1 = 5; is_j = 1;
        #1;
`ifdef HAZARD_FWD_EN
        exp = 10'b01_00_0000_1_0;
`else
        exp = 10'b00_00_1100_1_0;
`endif
        checks++;
        if (outs !== exp) begin
            $display("FAIL fwd_e_hit: got %b expected %b", outs, exp); errors++;
        end
        $display("fwd E hit x5: outs=%b", outs);
        tick();
        #1;
`ifdef HAZARD_FWD_EN
        exp = 10'b10_00_0000_1_0;
`else
        exp = 10'b00_00_1100_1_0;
`endif
        checks++;
        if (outs !== exp) begin
            $display("FAIL fwd_m_hit: got %b expected %b", outs, exp); errors++;
        end
        $display("fwd M hit x5: outs=%b", outs);
        tick();
        #1;
        exp = 10'b00_00_0000_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL fwd_drained: got %b expected %b", outs, exp); errors++;
        end
        $display("fwd x5 retired: outs=%b", outs);
        // writes to x0 never create a dependency
        clear_inputs(); dst_en = 1; r_dst = 0;
        tick();
        clear_inputs(); r_src1 = 0; r_src2 = 0; is_j = 1;
        #1;
        exp = 10'b00_00_0000_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL fwd_x0: got %b expected %b", outs, exp); errors++;
        end
        $display("fwd x0: outs=%b", outs);
        drain();
    endtask

    task automatic test_load_use;
        logic [9:0] exp;
        clear_inputs(); dst_en = 1; r_dst = 7; is_load = 1;   // lw x7 enters E
        tick();
        clear_inputs(); r_src2 = 7;
        #1;
        exp = 10'b00_00_1100_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL load_use_stall: got %b expected %b", outs, exp); errors++;
        end
        $display("load-use x7: outs=%b", outs);
        tick();
        #1;
`ifdef HAZARD_FWD_EN
        exp = 10'b00_10_0000_0_0;
`else
        exp = 10'b00_00_1100_0_0;
`endif
        checks++;
        if (outs !== exp) begin
            $display("FAIL load_use_after: got %b expected %b", outs, exp); errors++;
        end
        $display("load-use next cycle: outs=%b", outs);
        tick();
        #1;
        exp = 10'b00_00_0000_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL load_use_drained: got %b expected %b", outs, exp); errors++;
        end
        $display("load-use drained: outs=%b", outs);
        drain();
    endtask

    task automatic test_flush;
        logic [9:0] exp;
        clear_inputs(); is_b = 1; pre_taken = 0;        // branch predicted not-taken
        tick();
        clear_inputs(); real_taken = 1; dst_en = 1; r_dst = 9;
        #1;
        exp = 10'b00_00_0000_0_1;
        checks++;
        if (outs !== exp) begin
            $display("FAIL flush_mispredict: got %b expected %b", outs, exp); errors++;
        end
        $display("mispredict: outs=%b", outs);
        tick();
        // the killed x9 writer must not be in E
        clear_inputs(); r_src1 = 9;
        #1;
        exp = 10'b00_00_0000_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL flush_bubble: got %b expected %b", outs, exp); errors++;
        end
        $display("after flush: outs=%b", outs);
        clear_inputs(); is_b = 1; pre_taken = 1;        // branch predicted taken
        tick();
        clear_inputs(); real_taken = 1;
        #1;
        exp = 10'b00_00_0000_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL flush_correct: got %b expected %b", outs, exp); errors++;
        end
        $display("correct prediction: outs=%b", outs);
        real_taken = 0;
        #1;
        exp = 10'b00_00_0000_0_1;
        checks++;
        if (outs !== exp) begin
            $display("FAIL flush_comb: got %b expected %b", outs, exp); errors++;
        end
        $display("taken predicted, not taken: outs=%b", outs);
        m_cmiss = 1;
        #1;
        exp = 10'b00_00_1111_0_1;
        checks++;
        if (outs !== exp) begin
            $display("FAIL flush_with_dmiss: got %b expected %b", outs, exp); errors++;
        end
        $display("flush + data miss: outs=%b", outs);
        drain();
    endtask

    task automatic test_muldiv;
        logic [9:0] exp;
        clear_inputs(); is_d = 1;
        #1;
        exp = 10'b00_00_0000_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL md_issue: got %b expected %b", outs, exp); errors++;
        end
        $display("div issue: outs=%b", outs);
        tick();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            #1;
            exp = 10'b00_00_1110_0_0;
            checks++;
            if (outs !== exp) begin
                $display("FAIL md_busy_%0d: got %b expected %b", i, outs, exp); errors++;
            end
            $display("div busy cycle %0d: outs=%b", i, outs);
            tick();
        end
        fin = 1;
        #1;
        exp = 10'b00_00_0000_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL md_fin: got %b expected %b", outs, exp); errors++;
        end
        $display("div fin: outs=%b", outs);
        tick();
        fin = 0;
        #1;
        checks++;
        if (outs !== exp) begin
            $display("FAIL md_idle: got %b expected %b", outs, exp); errors++;
        end
        $display("div idle: outs=%b", outs);
        drain();
    endtask

    task automatic test_cache_miss;
        logic [9:0] exp;
        clear_inputs(); m_cmiss = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = 10'b00_00_1111_0_0;
            checks++;
            if (outs !== exp) begin
                $display("FAIL dmiss_%0d: got %b expected %b", i, outs, exp); errors++;
            end
            $display("data miss cycle %0d: outs=%b", i, outs);
            tick();
        end
        m_arrival = 1;
        #1;
        exp = 10'b00_00_0000_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL dmiss_arrival: got %b expected %b", outs, exp); errors++;
        end
        $display("data arrival: outs=%b", outs);
        clear_inputs(); f_cmiss = 1;
        #1;
        exp = 10'b00_00_1000_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL fmiss: got %b expected %b", outs, exp); errors++;
        end
        $display("fetch miss: outs=%b", outs);
        f_arrival = 1;
        #1;
        exp = 10'b00_00_0000_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL fmiss_arrival: got %b expected %b", outs, exp); errors++;
        end
        $display("fetch arrival: outs=%b", outs);
        drain();
    endtask

    task automatic test_reset_busy;
        logic [9:0] exp;
        clear_inputs(); is_m = 1;
        tick();
        clear_inputs();
        #1;
        exp = 10'b00_00_1110_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL rb_busy: got %b expected %b", outs, exp); errors++;
        end
        $display("mul busy: outs=%b", outs);
        rstn = 0;
        #1;
        exp = 10'b00_00_0000_0_0;
        checks++;
        if (outs !== exp) begin
            $display("FAIL rb_async: got %b expected %b", outs, exp); errors++;
        end
        $display("reset mid-busy: outs=%b", outs);
        tick();
        rstn = 1;
        #1;
        checks++;
        if (outs !== exp) begin
            $display("FAIL rb_release: got %b expected %b", outs, exp); errors++;
        end
        $display("reset released: outs=%b", outs);
        tick();
        #1;
        checks++;
        if (outs !== exp) begin
            $display("FAIL rb_after: got %b expected %b", outs, exp); errors++;
        end
        $display("after reset: outs=%b", outs);
        drain();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_flush();
        test_muldiv();
        test_cache_miss();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
